// File: rtl/ahb_pkg.sv
// Shared AHB encodings and slave state definitions, used by the SRAM slave
// and the master wrapper.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_DATA = 3'd2,
        S_ERR1 = 3'd3,
        S_ERR2 = 3'd4
    } slave_state_e;

    // Little-endian lane enables for an aligned access of the given size.
    function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] lo);
        case (size)
            HSIZE_BYTE: byte_en = 4'b0001 << lo;
            HSIZE_HALF: byte_en = lo[1] ? 4'b1100 : 4'b0011;
            default:    byte_en = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/ahb_sram_array.sv
// Word-organised SRAM: byte-enable synchronous write, asynchronous read.
// Contents are deliberately left uninitialised by reset.
module ahb_sram_array #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB slave fronting a word SRAM with programmable wait states and a
// two-cycle ERROR response for misaligned or out-of-region accesses.
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int          MEM_AW    = 8,
    parameter int          WAIT_CYC  = 1,
    parameter logic [31:0] BASE_ADDR = 32'h2000_0000
) (
    input  logic         H_clk,
    input  logic         H_resetn,
    input  logic         H_sel,
    input  logic [31:0]  H_addr,
    input  logic         H_write,
    input  logic [1:0]   H_trans,
    input  logic [2:0]   H_burst,
    input  logic [2:0]   H_size,
    input  logic [31:0]  H_wdata,
    input  logic         H_ready_in,
    output logic         H_readyout,
    output logic [1:0]   H_resp,
    output logic [31:0]  H_rdata,
    output slave_state_e dbg_state
);

    localparam logic [2:0] WAIT_LOAD = (WAIT_CYC > 0) ? 3'(WAIT_CYC - 1) : 3'd0;

    slave_state_e        state, state_nxt;
    logic [2:0]          wait_cnt, wait_cnt_nxt;
    logic [MEM_AW+1:0]   lat_addr;
    logic                lat_write;
    logic [2:0]          lat_size;
    logic                accept, addr_err, load;
    logic [31:0]         arr_rdata;
    logic                arr_we;
    logic                unused_ok;

    // Handshake: a transfer is offered while H_sel & H_trans[1]; it is taken only
    // on an edge where H_ready_in is high, and its data phase ends on the first
    // edge where H_readyout is high.
    assign accept   = H_sel & H_ready_in & H_trans[1];
    assign addr_err = (H_size > HSIZE_WORD)
                    | ((H_size == HSIZE_HALF) & H_addr[0])
                    | ((H_size == HSIZE_WORD) & (|H_addr[1:0]))
                    | (H_addr[31:MEM_AW+2] != BASE_ADDR[31:MEM_AW+2]);

    assign unused_ok = ^H_burst;

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        load         = 1'b0;
        case (state)
            S_IDLE, S_DATA, S_ERR2: begin
                if (accept) begin
                    load         = 1'b1;
                    wait_cnt_nxt = WAIT_LOAD;
                    if (addr_err)          state_nxt = S_ERR1;
                    else if (WAIT_CYC > 0) state_nxt = S_WAIT;
                    else                   state_nxt = S_DATA;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                if (wait_cnt == 3'd0) state_nxt = S_DATA;
                else                  wait_cnt_nxt = wait_cnt - 3'd1;
            end
            S_ERR1:  state_nxt = S_ERR2;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge H_clk or negedge H_resetn) begin
        if (!H_resetn) begin
            state     <= S_IDLE;
            wait_cnt  <= 3'd0;
            lat_addr  <= '0;
            lat_write <= 1'b0;
            lat_size  <= 3'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (load) begin
                lat_addr  <= H_addr[MEM_AW+1:0];
                lat_write <= H_write;
                lat_size  <= H_size;
            end
        end
    end

    // Errored transfers never reach S_DATA, so the array is only touched by legal writes.
    assign arr_we = (state == S_DATA) & lat_write;

    ahb_sram_array #(.AW(MEM_AW)) u_array (
        .clk   (H_clk),
        .we    (arr_we),
        .be    (byte_en(lat_size, lat_addr[1:0])),
        .addr  (lat_addr[MEM_AW+1:2]),
        .wdata (H_wdata),
        .rdata (arr_rdata)
    );

    assign H_readyout = (state != S_WAIT) && (state != S_ERR1);
    assign H_resp     = ((state == S_ERR1) || (state == S_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    assign H_rdata    = ((state == S_DATA) && !lat_write) ? arr_rdata : 32'h0;
    assign dbg_state  = state;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: one instance with WAIT_CYC=0 and one with WAIT_CYC=1
// share the bus signals; cur selects which one is addressed.
module tb_ahb_sram_slave;
    import ahb_pkg::*;

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [2:0]  sz;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic [1:0]  exp_resp;
        int          exp_waits;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         sel, write, stall;
    logic [31:0]  addr, wdata;
    logic [1:0]   trans;
    logic [2:0]   burst, size;
    int           cur;

    logic         ro0, ro1;
    logic [1:0]   rs0, rs1;
    logic [31:0]  rd0, rd1;
    slave_state_e st0, st1;

    logic         readyout;
    logic [1:0]   resp;
    logic [31:0]  rdata;
    logic [2:0]   dstate;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mdl [2][16];
    int          waitc [2];

    always #5 clk = ~clk;

    ahb_sram_slave #(.MEM_AW(8), .WAIT_CYC(0), .BASE_ADDR(32'h2000_0000)) u0 (
        .H_clk(clk), .H_resetn(rst_n), .H_sel(sel && cur == 0), .H_addr(addr),
        .H_write(write), .H_trans(trans), .H_burst(burst), .H_size(size),
        .H_wdata(wdata), .H_ready_in(ro0 & ~stall), .H_readyout(ro0),
        .H_resp(rs0), .H_rdata(rd0), .dbg_state(st0)
    );

    ahb_sram_slave #(.MEM_AW(8), .WAIT_CYC(1), .BASE_ADDR(32'h2000_0000)) u1 (
        .H_clk(clk), .H_resetn(rst_n), .H_sel(sel && cur == 1), .H_addr(addr),
        .H_write(write), .H_trans(trans), .H_burst(burst), .H_size(size),
        .H_wdata(wdata), .H_ready_in(ro1 & ~stall), .H_readyout(ro1),
        .H_resp(rs1), .H_rdata(rd1), .dbg_state(st1)
    );

    assign readyout = (cur == 1) ? ro1 : ro0;
    assign resp     = (cur == 1) ? rs1 : rs0;
    assign rdata    = (cur == 1) ? rd1 : rd0;
    assign dstate   = (cur == 1) ? st1 : st0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic bus_idle();
        sel   = 1'b0;
        trans = HTRANS_IDLE;
        write = 1'b0;
        addr  = 32'h0;
        size  = HSIZE_WORD;
        burst = HBURST_SINGLE;
    endtask

    // Single non-pipelined transfer; waits counts readyout-low data-phase cycles.
    task automatic do_xfer(input logic w, input logic [31:0] a, input logic [2:0] sz,
                           input logic [31:0] wd, output logic [31:0] rd,
                           output logic [1:0] resp_first, output logic [1:0] resp_last,
                           output int waits);
        @(negedge clk);
        sel = 1'b1; trans = HTRANS_NONSEQ; write = w; addr = a; size = sz;
        burst = HBURST_SINGLE;
        @(negedge clk);
        bus_idle();
        wdata      = wd;
        waits      = 0;
        resp_first = resp;
        while (!readyout && waits < 16) begin
            waits++;
            @(negedge clk);
        end
        rd        = rdata;
        resp_last = resp;
    endtask

    function automatic bit exp_err(input logic [2:0] sz, input logic [31:0] a);
        if (sz > 3'd2) return 1'b1;
        if (a % (32'd1 << sz) != 0) return 1'b1;
        return !(a >= 32'h2000_0000 && a < 32'h2000_0400);
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        vec_t        vecs [13];
        logic [31:0] rd, a, wd;
        logic [1:0]  rf, rl;
        logic [2:0]  sz;
        logic        w, err;
        int          waits, k, kind, idx, nb, lane;
        logic [1:0]  bt_trans [5];
        logic [31:0] bt_addr [5];
        logic [31:0] bt_data [5];

        waitc[0] = 0;
        waitc[1] = 1;

        vecs[0]  = '{1'b1, 32'h2000_0010, HSIZE_WORD, 32'h1111_1111, 32'h0, HRESP_OKAY, 1};
        vecs[1]  = '{1'b1, 32'h2000_0013, HSIZE_BYTE, 32'hA500_0000, 32'h0, HRESP_OKAY, 1};
        vecs[2]  = '{1'b0, 32'h2000_0010, HSIZE_WORD, 32'h0, 32'hA511_1111, HRESP_OKAY, 1};
        vecs[3]  = '{1'b1, 32'h2000_0012, HSIZE_HALF, 32'h55AA_0000, 32'h0, HRESP_OKAY, 1};
        vecs[4]  = '{1'b0, 32'h2000_0010, HSIZE_WORD, 32'h0, 32'h55AA_1111, HRESP_OKAY, 1};
        vecs[5]  = '{1'b1, 32'h2000_0000, HSIZE_WORD, 32'h0BAD_F00D, 32'h0, HRESP_OKAY, 1};
        vecs[6]  = '{1'b0, 32'h2000_0402, HSIZE_WORD, 32'h0, 32'h0, HRESP_ERROR, 1};
        vecs[7]  = '{1'b1, 32'h2000_0402, HSIZE_WORD, 32'hFFFF_FFFF, 32'h0, HRESP_ERROR, 1};
        vecs[8]  = '{1'b1, 32'h2000_0001, HSIZE_HALF, 32'hFFFF_FFFF, 32'h0, HRESP_ERROR, 1};
        vecs[9]  = '{1'b1, 32'h2000_0000, 3'd3, 32'hFFFF_FFFF, 32'h0, HRESP_ERROR, 1};
        vecs[10] = '{1'b1, 32'h1FFF_FFFC, HSIZE_WORD, 32'hFFFF_FFFF, 32'h0, HRESP_ERROR, 1};
        vecs[11] = '{1'b0, 32'h2000_0000, HSIZE_WORD, 32'h0, 32'h0BAD_F00D, HRESP_OKAY, 1};
        vecs[12] = '{1'b0, 32'h2000_0011, HSIZE_BYTE, 32'h0, 32'h55AA_1111, HRESP_OKAY, 1};

        // Clock/reset
        cur   = 0;
        stall = 1'b0;
        wdata = 32'h0;
        bus_idle();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready0", 32'(ro0), 32'd1);
        chk("rst_resp0",  32'(rs0), 32'd0);
        chk("rst_rdata0", rd0, 32'h0);
        chk("rst_state1", 32'(st1), 32'(S_IDLE));
        chk("rst_ready1", 32'(ro1), 32'd1);
        rst_n = 1'b1;

        // Back-to-back word write then read, WAIT_CYC=1
        cur = 1;
        @(negedge clk);
        sel = 1'b1; trans = HTRANS_NONSEQ; write = 1'b1; addr = 32'h2000_0010; size = HSIZE_WORD;
        @(negedge clk);
        chk("b2b_w_wait_ready", 32'(readyout), 32'd0);
        wdata = 32'hDEAD_BEEF;
        write = 1'b0;
        @(negedge clk);
        chk("b2b_w_done_ready", 32'(readyout), 32'd1);
        chk("b2b_w_done_resp", 32'(resp), 32'd0);
        @(negedge clk);
        bus_idle();
        chk("b2b_r_wait_ready", 32'(readyout), 32'd0);
        @(negedge clk);
        chk("b2b_r_done_ready", 32'(readyout), 32'd1);
        chk("b2b_r_rdata", rdata, 32'hDEAD_BEEF);
        chk("b2b_r_resp", 32'(resp), 32'd0);
        @(negedge clk);
        chk("b2b_idle_rdata", rdata, 32'h0);
        chk("b2b_idle_state", 32'(dstate), 32'(S_IDLE));

        // Table-driven directed vectors on the WAIT_CYC=1 instance
        for (int i = 0; i < 13; i++) begin
            do_xfer(vecs[i].w, vecs[i].a, vecs[i].sz, vecs[i].wd, rd, rf, rl, waits);
            chk($sformatf("vec%0d_waits", i), 32'(waits), 32'(vecs[i].exp_waits));
            chk($sformatf("vec%0d_resp_first", i), 32'(rf),
                (vecs[i].exp_resp == HRESP_ERROR) ? 32'd1 : 32'd0);
            chk($sformatf("vec%0d_resp_last", i), 32'(rl), 32'(vecs[i].exp_resp));
            if (!vecs[i].w && vecs[i].exp_resp == HRESP_OKAY)
                chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
        end

        // INCR4 with one BUSY inserted, WAIT_CYC=0
        cur = 0;
        bt_trans = '{HTRANS_NONSEQ, HTRANS_SEQ, HTRANS_BUSY, HTRANS_SEQ, HTRANS_SEQ};
        bt_addr  = '{32'h0, 32'h4, 32'h8, 32'h8, 32'hC};
        bt_data  = '{32'd1, 32'd2, 32'd0, 32'd3, 32'd4};
        for (int i = 0; i <= 5; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk($sformatf("incr4_ready%0d", i), 32'(readyout), 32'd1);
                chk($sformatf("incr4_resp%0d", i), 32'(resp), 32'd0);
                if (bt_trans[i-1] != HTRANS_BUSY) wdata = bt_data[i-1];
            end
            if (i < 5) begin
                sel = 1'b1; trans = bt_trans[i]; write = 1'b1;
                addr = 32'h2000_0000 + bt_addr[i]; size = HSIZE_WORD; burst = HBURST_INCR4;
            end else begin
                bus_idle();
            end
        end
        for (int i = 0; i < 4; i++) begin
            do_xfer(1'b0, 32'h2000_0000 + 32'(4 * i), HSIZE_WORD, 32'h0, rd, rf, rl, waits);
            chk($sformatf("incr4_readback%0d", i), rd, 32'(i + 1));
        end

        // Reset asserted during S_WAIT drops the pending write
        cur = 1;
        do_xfer(1'b1, 32'h2000_0020, HSIZE_WORD, 32'h1234_5678, rd, rf, rl, waits);
        @(negedge clk);
        sel = 1'b1; trans = HTRANS_NONSEQ; write = 1'b1; addr = 32'h2000_0020; size = HSIZE_WORD;
        @(negedge clk);
        bus_idle();
        wdata = 32'hFFFF_FFFF;
        chk("rstmid_wait_ready", 32'(readyout), 32'd0);
        chk("rstmid_wait_state", 32'(dstate), 32'(S_WAIT));
        rst_n = 1'b0;
        #1;
        chk("rstmid_ready", 32'(readyout), 32'd1);
        chk("rstmid_resp", 32'(resp), 32'd0);
        chk("rstmid_rdata", rdata, 32'h0);
        chk("rstmid_state", 32'(dstate), 32'(S_IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        do_xfer(1'b0, 32'h2000_0020, HSIZE_WORD, 32'h0, rd, rf, rl, waits);
        chk("rstmid_old_data", rd, 32'h1234_5678);

        // Offer while H_ready_in is low must be ignored
        do_xfer(1'b1, 32'h2000_0030, HSIZE_WORD, 32'h0000_7777, rd, rf, rl, waits);
        @(negedge clk);
        stall = 1'b1;
        sel = 1'b1; trans = HTRANS_NONSEQ; write = 1'b1; addr = 32'h2000_0030; size = HSIZE_WORD;
        @(negedge clk);
        wdata = 32'hCAFE_F00D;
        chk("stall_state_a", 32'(dstate), 32'(S_IDLE));
        chk("stall_ready", 32'(readyout), 32'd1);
        @(negedge clk);
        chk("stall_state_b", 32'(dstate), 32'(S_IDLE));
        bus_idle();
        stall = 1'b0;
        do_xfer(1'b0, 32'h2000_0030, HSIZE_WORD, 32'h0, rd, rf, rl, waits);
        chk("stall_no_write", rd, 32'h0000_7777);

        // Randomized transfers against the reference memory model
        for (int d = 0; d < 2; d++) begin
            cur = d;
            for (int i = 0; i < 16; i++) begin
                wd = $urandom;
                mdl[d][i] = wd;
                do_xfer(1'b1, 32'h2000_0100 + 32'(4 * i), HSIZE_WORD, wd, rd, rf, rl, waits);
            end
        end
        for (int n = 0; n < 100; n++) begin
            k    = $urandom_range(0, 1);
            cur  = k;
            kind = $urandom_range(0, 9);
            w    = 1'($urandom_range(0, 1));
            sz   = 3'($urandom_range(0, 2));
            a    = 32'h2000_0100 + 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) a = a - (a % (32'd1 << sz));
            if (kind == 0) sz = 3'($urandom_range(3, 7));
            if (kind == 1) a = a + 32'h400;
            wd  = $urandom;
            err = exp_err(sz, a);
            do_xfer(w, a, sz, wd, rd, rf, rl, waits);
            chk($sformatf("rnd%0d_waits", n), 32'(waits), err ? 32'd1 : 32'(waitc[k]));
            chk($sformatf("rnd%0d_resp_first", n), 32'(rf), err ? 32'd1 : 32'd0);
            chk($sformatf("rnd%0d_resp_last", n), 32'(rl), err ? 32'd1 : 32'd0);
            if (!err) begin
                idx = int'((a - 32'h2000_0100) >> 2);
                if (w) begin
                    nb = 1 << sz;
                    for (int b = 0; b < nb; b++) begin
                        lane = int'(a % 4) + b;
                        mdl[k][idx][8*lane +: 8] = wd[8*lane +: 8];
                    end
                end else begin
                    chk($sformatf("rnd%0d_rdata", n), rd, mdl[k][idx]);
                end
            end
        end
        for (int d = 0; d < 2; d++) begin
            cur = d;
            for (int i = 0; i < 16; i++) begin
                do_xfer(1'b0, 32'h2000_0100 + 32'(4 * i), HSIZE_WORD, 32'h0, rd, rf, rl, waits);
                chk($sformatf("final_dut%0d_word%0d", d, i), rd, mdl[d][i]);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
